// File: rtl/adder_pipe_initiator_pkg.sv
// Shared definitions for the adder_pipe_initiator block.
//   state_e  : initiator FSM state (RUN / ERR)
//   W_DEF    : default operand/result width
//   MCNT_W   : width of the saturating mismatch counter
//   ADDER_INC: constant the downstream adder adds to a + b
//   cnt_w()  : width needed to hold an occupancy count 0..depth
package adder_pipe_initiator_pkg;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_e;

    localparam int W_DEF     = 16;
    localparam int MCNT_W    = 8;
    localparam int ADDER_INC = 1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/adder_pipe_initiator_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : empties the FIFO (wins over a same-cycle push/pop)
//   push_i     : write wdata_i when not full
//   wdata_i    : write data
//   pop_i      : drop the head entry when not empty
//   rdata_o    : head entry, valid whenever empty_o is low
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : current occupancy
module sync_fifo_fwft
    import adder_pipe_initiator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed once counted in.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/adder_pipe_initiator.sv
// Initiator/checker for a pipelined a + b + 1 adder.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd_valid/ready   : upstream command port, operands cmd_a / cmd_b
//   start, a, b       : one-cycle issue pulse and operands to the adder
//   y, valid          : adder result return
//   rsp_valid/ready   : downstream FWFT response port, rsp_data / rsp_mismatch
//   mismatch_cnt      : saturating count of results differing from prediction
//   err_unexp         : sticky, result returned with nothing outstanding
//   err_timeout       : sticky, outstanding result older than TMO cycles
//   clr_err           : synchronous clear of errors/counter, leaves ERR
//   dbg_state         : current FSM state
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; ready never depends combinationally on the partner's valid,
// and a source holds valid/data stable until the transfer occurs.
module adder_pipe_initiator
    import adder_pipe_initiator_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = 4,
    parameter int TMO   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W-1:0]      cmd_a,
    input  logic [W-1:0]      cmd_b,
    output logic              start,
    output logic [W-1:0]      a,
    output logic [W-1:0]      b,
    input  logic [W-1:0]      y,
    input  logic              valid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_mismatch,
    output logic [MCNT_W-1:0] mismatch_cnt,
    output logic              err_unexp,
    output logic              err_timeout,
    input  logic              clr_err,
    output state_e            dbg_state
);

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = $clog2(TMO + 1);

    state_e            state_q;
    logic              start_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [AW-1:0]     age_q, age_d;
    logic              err_unexp_q;
    logic              err_timeout_q;

    logic [CW-1:0]     inflight;
    logic [CW-1:0]     rsp_count;
    logic [CW:0]       used;
    logic [W-1:0]      exp_sum;
    logic [W-1:0]      exp_head;
    logic              exp_empty, exp_full;
    logic [W:0]        rsp_head;
    logic              rsp_empty, rsp_full;
    logic              accept, ret, unexp, mism, timeout, rsp_pop;

    // The expectation FIFO holds exactly one entry per outstanding issue,
    // so its occupancy is the in-flight count.
    assign used      = {1'b0, inflight} + {1'b0, rsp_count};
    assign cmd_ready = (state_q == ST_RUN) && (used != (CW+1)'(DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign ret       = valid && !exp_empty;
    assign unexp     = valid && exp_empty;
    assign exp_sum   = cmd_a + cmd_b + W'(ADDER_INC);
    assign mism      = (y != exp_head);
    // A return in the same cycle proves the head is alive, so it suppresses timeout.
    assign timeout   = (inflight != '0) && !ret && (age_q == AW'(TMO - 1));
    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(DEPTH)) u_exp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (timeout),
        .push_i  (accept && !exp_full),
        .wdata_i (exp_sum),
        .pop_i   (ret),
        .rdata_o (exp_head),
        .full_o  (exp_full),
        .empty_o (exp_empty),
        .count_o (inflight)
    );

    sync_fifo_fwft #(.WIDTH(W + 1), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (ret && !rsp_full),
        .wdata_i ({mism, y}),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    // Head storage is not reset, so the data path is gated while empty.
    assign rsp_data     = rsp_valid ? rsp_head[W-1:0] : '0;
    assign rsp_mismatch = rsp_valid && rsp_head[W];

    always_comb begin
        age_d = age_q;
        if (timeout || ret || (accept && inflight == '0)) begin
            age_d = '0;
        end else if (inflight != '0) begin
            age_d = age_q + 1'b1;
        end
    end

    // A clear coinciding with a new mismatch still counts that mismatch.
    always_comb begin
        mcnt_d = clr_err ? '0 : mcnt_q;
        if (ret && mism && mcnt_d != '1) begin
            mcnt_d = mcnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            start_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            mcnt_q        <= '0;
            age_q         <= '0;
            err_unexp_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            start_q <= accept;
            if (accept) begin
                a_q <= cmd_a;
                b_q <= cmd_b;
            end
            mcnt_q <= mcnt_d;
            age_q  <= age_d;

            if (unexp)        err_unexp_q <= 1'b1;
            else if (clr_err) err_unexp_q <= 1'b0;

            if (timeout)      err_timeout_q <= 1'b1;
            else if (clr_err) err_timeout_q <= 1'b0;

            case (state_q)
                ST_RUN:  if (timeout) state_q <= ST_ERR;
                ST_ERR:  if (clr_err) state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign start        = start_q;
    assign a            = a_q;
    assign b            = b_q;
    assign mismatch_cnt = mcnt_q;
    assign err_unexp    = err_unexp_q;
    assign err_timeout  = err_timeout_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_adder_pipe_initiator.sv
module tb_adder_pipe_initiator;
    import adder_pipe_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        start;
    logic [15:0] a, b;
    logic [15:0] y;
    logic        valid;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_mismatch;
    logic [7:0]  mismatch_cnt;
    logic        err_unexp;
    logic        err_timeout;
    logic        clr_err = 1'b0;
    state_e      dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [16:0] exp_q[$];     // {mismatch, data}
    int start_cyc_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired n_errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- bench adder (2-stage, a+b+1) ----------------
    int          adder_n = 0;
    int          drop_at = -1;
    int          corrupt_at = -1;
    logic        pv1, pv2;
    logic [15:0] py1, py2;
    logic        inj_valid = 1'b0;
    logic [15:0] inj_y = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv1 <= 1'b0;
            pv2 <= 1'b0;
            py1 <= '0;
            py2 <= '0;
        end else begin
            pv1 <= 1'b0;
            if (start) begin
                adder_n <= adder_n + 1;
                pv1 <= (adder_n != drop_at);
                py1 <= a + b + ((adder_n == corrupt_at) ? 16'd2 : 16'd1);
            end
            pv2 <= pv1;
            py2 <= py1;
        end
    end

    assign valid = pv2 | inj_valid;
    assign y     = inj_valid ? inj_y : py2;

    always @(negedge clk) if (start) start_cyc_q.push_back(cyc);

    adder_pipe_initiator #(.W(16), .DEPTH(4), .TMO(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .start        (start),
        .a            (a),
        .b            (b),
        .y            (y),
        .valid        (valid),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_mismatch (rsp_mismatch),
        .mismatch_cnt (mismatch_cnt),
        .err_unexp    (err_unexp),
        .err_timeout  (err_timeout),
        .clr_err      (clr_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, expv);
        end
    endtask

    // ---------------- drivers (called at a negedge) ----------------
    task automatic send_cmd(input logic [15:0] ca, input logic [15:0] cb, input logic [16:0] expv);
        int t = 0;
        exp_q.push_back(expv);
        cmd_valid = 1'b1;
        cmd_a = ca;
        cmd_b = cb;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp(input string tag);
        int t = 0;
        logic [16:0] e;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected"}, 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_data"}, 32'(rsp_data), 32'(e[15:0]));
                check({tag, "_mism"}, 32'(rsp_mismatch), 32'(e[16]));
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("rst_start", 32'(start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_mcnt", 32'(mismatch_cnt), 32'd0);
        check("rst_err_unexp", 32'(err_unexp), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_RUN));

        // Single command with exact latency
        send_cmd(16'h0003, 16'h0004, {1'b0, 16'h0008});
        check("t1_start", 32'(start), 32'd1);
        check("t1_a", 32'(a), 32'h0003);
        check("t1_b", 32'(b), 32'h0004);
        @(negedge clk);
        check("t1_start_low", 32'(start), 32'd0);
        check("t1_rsp_early0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t1_rsp_early1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t1_rsp_on_time", 32'(rsp_valid), 32'd1);
        pop_rsp("t1");

        // Wrap-around
        send_cmd(16'hFFFF, 16'h0000, {1'b0, 16'h0000});
        send_cmd(16'hFFFF, 16'hFFFF, {1'b0, 16'hFFFF});
        pop_rsp("t2a");
        pop_rsp("t2b");

        // Back-pressure: 6 commands, responses held
        repeat (2) @(negedge clk);
        start_cyc_q.delete();
        fork
            begin
                send_cmd(16'h0010, 16'h0001, {1'b0, 16'h0012});
                send_cmd(16'h0020, 16'h0002, {1'b0, 16'h0023});
                send_cmd(16'h0030, 16'h0003, {1'b0, 16'h0034});
                send_cmd(16'h0040, 16'h0004, {1'b0, 16'h0045});
                send_cmd(16'h0050, 16'h0005, {1'b0, 16'h0056});
                send_cmd(16'h0060, 16'h0006, {1'b0, 16'h0067});
            end
            begin
                repeat (12) @(negedge clk);
                check("t3_starts", 32'(start_cyc_q.size()), 32'd4);
                if (start_cyc_q.size() == 4)
                    check("t3_consecutive", 32'(start_cyc_q[3] - start_cyc_q[0]), 32'd3);
                check("t3_cmd_ready_low", 32'(cmd_ready), 32'd0);
                for (int i = 0; i < 6; i++) pop_rsp("t3");
            end
        join
        check("t3_total_starts", 32'(start_cyc_q.size()), 32'd6);

        // Mismatch on 2nd of 3
        corrupt_at = adder_n + 1;
        send_cmd(16'h0001, 16'h0002, {1'b0, 16'h0004});
        send_cmd(16'h0010, 16'h0020, {1'b1, 16'h0032});
        send_cmd(16'h0100, 16'h0200, {1'b0, 16'h0301});
        pop_rsp("t4a");
        pop_rsp("t4b");
        pop_rsp("t4c");
        corrupt_at = -1;
        check("t4_mcnt", 32'(mismatch_cnt), 32'd1);
        pulse_clr();
        check("t4_mcnt_clr", 32'(mismatch_cnt), 32'd0);

        // Timeout
        drop_at = adder_n;
        send_cmd(16'h0005, 16'h0006, {1'b0, 16'h000C});
        check("t5_start", 32'(start), 32'd1);
        repeat (7) @(negedge clk);
        check("t5_tmo_early", 32'(err_timeout), 32'd0);
        @(negedge clk);
        check("t5_tmo_set", 32'(err_timeout), 32'd1);
        check("t5_state_err", 32'(dbg_state), 32'(ST_ERR));
        check("t5_cmd_ready_low", 32'(cmd_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("t5_cmd_ready_held", 32'(cmd_ready), 32'd0);
        check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        drop_at = -1;
        exp_q.delete();
        pulse_clr();
        check("t5_tmo_clr", 32'(err_timeout), 32'd0);
        check("t5_cmd_ready_back", 32'(cmd_ready), 32'd1);
        send_cmd(16'h0007, 16'h0008, {1'b0, 16'h0010});
        pop_rsp("t5_after");

        // Unexpected return
        inj_y = 16'h1234;
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        check("t6_err_unexp", 32'(err_unexp), 32'd1);
        check("t6_state_run", 32'(dbg_state), 32'(ST_RUN));
        repeat (3) @(negedge clk);
        check("t6_no_rsp", 32'(rsp_valid), 32'd0);

        // Reset with two commands in flight
        send_cmd(16'h0A00, 16'h00B0, {1'b0, 16'h0AB1});
        send_cmd(16'h0C00, 16'h00D0, {1'b0, 16'h0CD1});
        rst_n = 1'b0;
        #1;
        check("t7_start", 32'(start), 32'd0);
        check("t7_a", 32'(a), 32'd0);
        check("t7_b", 32'(b), 32'd0);
        check("t7_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t7_rsp_data", 32'(rsp_data), 32'd0);
        check("t7_rsp_mism", 32'(rsp_mismatch), 32'd0);
        check("t7_mcnt", 32'(mismatch_cnt), 32'd0);
        check("t7_err_unexp", 32'(err_unexp), 32'd0);
        check("t7_err_timeout", 32'(err_timeout), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("t7_rsp_empty", 32'(rsp_valid), 32'd0);
        check("t7_no_unexp", 32'(err_unexp), 32'd0);
        send_cmd(16'h1111, 16'h2222, {1'b0, 16'h3334});
        pop_rsp("t7_after");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_pipe_initiator.md
Name: adder_pipe_initiator

Overview:
- Initiator/checker for the 2-stage `a + b + 1` pipelined adder interface (`start`/`a`/`b` out, `y`/`valid` back).
- Accepts commands from an upstream ready/valid port and issues them to the adder.
- Predicts each result and pairs it with the returned `y` in issue order.
- Buffers responses behind a ready/valid port, flags mismatches and protocol faults, and throttles issue so no returning result is ever lost.

Parameters:
- `W`, 16: operand/result width; must match the adder.
- `DEPTH`, 4: response/expectation buffer entries; must be at least 3.
- `TMO`, 8: cycles allowed from `start` to the matching `valid` before a timeout is flagged.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  upstream command valid
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_a`  in  W  operand a
- `cmd_b`  in  W  operand b
- `start`  out  1  one-cycle issue pulse to adder
- `a`  out  W  operand to adder, meaningful when `start`=1
- `b`  out  W  operand to adder, meaningful when `start`=1
- `y`  in  W  adder result
- `valid`  in  1  adder result valid
- `rsp_valid`  out  1  response buffer non-empty
- `rsp_ready`  in  1  downstream pops head when high with `rsp_valid`
- `rsp_data`  out  W  head response `y`
- `rsp_mismatch`  out  1  head response differs from prediction
- `mismatch_cnt`  out  8  saturating count of mismatches
- `err_unexp`  out  1  sticky: `valid` seen with nothing outstanding
- `err_timeout`  out  1  sticky: `TMO` expired
- `clr_err`  in  1  synchronous clear of errors and counter

Behaviour:
- Reset values: all outputs 0; buffers empty; state RUN; `cmd_ready` evaluates to 1 after reset.
- States:
  - RUN: normal operation.
  - ERR: entered on timeout; commands blocked.
  - ERR -> RUN only on `clr_err`=1.
  - `err_unexp` does not change state.
- Credit: `credit = DEPTH - (inflight + rsp_count)`.
  - `cmd_ready = (state==RUN) && credit != 0`.
  - `cmd_ready` is decoded from registered state only, with no combinational path from `cmd_valid`.
- Issue:
  - Accept registers `start`=1, `a`=`cmd_a`, `b`=`cmd_b` for exactly the next cycle; otherwise `start`=0.
  - `a` and `b` hold their last values while idle.
  - Back-to-back accepts give a `start` on consecutive cycles.
  - At accept, `exp = (cmd_a + cmd_b + 1) mod 2^W` is pushed into the expectation FIFO and `inflight` is incremented.
- Adder latency: `valid` is expected 2 cycles after `start`.
  - The block does not assume it; matching is by order only.
- Return, when `valid`=1 and `inflight` != 0:
  - Pop the expectation.
  - Push `{y, y != exp}` into the response FIFO.
  - `inflight` -1.
  - If mismatch, `mismatch_cnt` +1, saturating at 255.
- Simultaneous accept and return in one cycle: both take effect, and `inflight` is unchanged.
- Return when `inflight`=0: `err_unexp` <= 1; nothing pushed; counts unchanged.
- Response port is first-word-fall-through:
  - `rsp_valid` = response FIFO non-empty.
  - `rsp_data` and `rsp_mismatch` show the head entry.
  - Pop on `rsp_valid && rsp_ready`.
  - Push and pop in the same cycle are both honoured.
- Credit guarantee: `inflight + rsp_count <= DEPTH` always holds, so a return never finds the response FIFO full.
- Timeout:
  - The age counter resets on each `start` when `inflight` was 0, and on each return.
  - It counts cycles while `inflight` != 0.
  - On reaching `TMO`: `err_timeout` <= 1, state -> ERR, expectation FIFO flushed, `inflight` <= 0.
  - Already-buffered responses stay poppable.
- `clr_err`: clears `err_unexp`, `err_timeout` and `mismatch_cnt`, and sets state RUN. A `clr_err` coinciding with a new error gives the error priority (the flag ends set).
- Reset mid-operation: everything returns to reset values immediately; pending expectations and responses are discarded.

Decomposition:
- Shared package:
  - state enum (RUN, ERR);
  - `W` default;
  - `MCNT_W`=8;
  - `ADDER_INC`=1 constant;
  - a count-width function `clog2(DEPTH+1)`.
- Sub-module `sync_fifo_fwft` (params width and depth; ports push, pop, data, full, empty, count, flush).
  - Instantiated twice: expectation (width `W`) and response (width `W+1`).

Test Plan:
- Single command: `cmd` a=0x0003, b=0x0004 -> `start` one cycle after accept with a=0x0003, b=0x0004. Bench adder returns 0x0008 two cycles later -> `rsp_valid`=1, `rsp_data`=0x0008, `rsp_mismatch`=0.
- Wrap-around: a=0xFFFF, b=0x0000 -> expected 0x0000. Adder returns 0x0000 -> `rsp_mismatch`=0. a=0xFFFF, b=0xFFFF -> expected 0xFFFF.
- Back-pressure (`DEPTH`=4, `rsp_ready`=0): 6 back-to-back commands -> exactly 4 `start` pulses on consecutive cycles, then `cmd_ready`=0. Raise `rsp_ready` -> 4 in-order responses, then the remaining 2 are issued and returned.
- Mismatch: bench returns `y`+1 for the 2nd of 3 commands -> `rsp_mismatch` = 0, 1, 0 and `mismatch_cnt`=1. Pulse `clr_err` -> `mismatch_cnt`=0.
- Timeout: bench suppresses `valid` for one command -> `err_timeout`=1 exactly `TMO`=8 cycles after its `start`, and `cmd_ready`=0 until `clr_err`. After `clr_err` a new command completes normally.
- Unexpected and reset: `valid`=1 with no outstanding command -> `err_unexp`=1 and no response. Assert `rst_n`=0 with 2 commands in flight -> all outputs 0 and FIFOs empty; after release, `cmd_ready`=1.
